// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch stage.
//   INSTR_W         instruction / address width
//   DEF_RESET_PC    default PC loaded on reset
//   DEF_NOP_INSTR   default bubble word
//   fetch_state_e   fetch FSM states (FETCH, HOLD)
package mips_pkg;

    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] DEF_NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holder for a fetched word and its PC+4.
// It catches the response that arrives while the IF/ID register is stalled.
// Ports:
//   Clk, Rst          clock, async active-low reset
//   load              capture data_in / pcp4_in
//   drain             entry consumed by IF/ID
//   clear             discard the entry (flush); takes priority over load
//   data_in, pcp4_in  word and PC+4 to capture
//   full              entry valid
//   data, pcp4        held word and PC+4
import mips_pkg::*;

module fetch_skid_buffer (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               load,
    input  logic               drain,
    input  logic               clear,
    input  logic [INSTR_W-1:0] data_in,
    input  logic [INSTR_W-1:0] pcp4_in,
    output logic               full,
    output logic [INSTR_W-1:0] data,
    output logic [INSTR_W-1:0] pcp4
);

    logic               full_q, full_d;
    logic [INSTR_W-1:0] data_q, data_d;
    logic [INSTR_W-1:0] pcp4_q, pcp4_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        pcp4_d = pcp4_q;
        if (clear) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d = 1'b1;
            data_d = data_in;
            pcp4_d = pcp4_in;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            full_q <= 1'b0;
            data_q <= '0;
            pcp4_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            pcp4_q <= pcp4_d;
        end
    end

    assign full = full_q;
    assign data = data_q;
    assign pcp4 = pcp4_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// PC-sequencing fetch stage with IF/ID output register.
// Optional build macro: FETCH_PERF_CNT_EN adds BubbleCount.
//
// state | meaning
// FETCH | request outstanding at IMemAddr=PC (request held off for the
//       | first cycle after reset release)
// HOLD  | stalled with a word parked in the skid buffer; no request
//
// Ports:
//   Clk, Rst                      clock, async active-low reset
//   Stall                         hazard hold of PC and IF/ID
//   PCSrc, BranchTarget           taken branch redirect
//   IMemReq, IMemAddr             fetch request / address
//   IMemReady, IMemRdata          memory accept and same-cycle data
//   Instruction, PCPlus4, Valid   IF/ID register
//   BubbleCount                   cycles with Valid=0 (FETCH_PERF_CNT_EN only)
import mips_pkg::*;

module instruction_fetch_stage #(
    parameter logic [INSTR_W-1:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Stall,
    input  logic               PCSrc,
    input  logic [INSTR_W-1:0] BranchTarget,
    output logic               IMemReq,
    output logic [INSTR_W-1:0] IMemAddr,
    input  logic               IMemReady,
    input  logic [INSTR_W-1:0] IMemRdata,
    output logic [INSTR_W-1:0] Instruction,
    output logic [INSTR_W-1:0] PCPlus4,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]        BubbleCount,
`endif
    output logic               Valid
);

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] pcp4_q, pcp4_d;
    logic               valid_q, valid_d;
    logic               req_en_q, req_en_d;
    logic               pend_q, pend_d;
    logic [INSTR_W-1:0] tgt_q, tgt_d;

    logic               skid_load, skid_drain, skid_clear, skid_full;
    logic [INSTR_W-1:0] skid_data, skid_pcp4;
    logic [INSTR_W-1:0] pc_plus4;
    logic [INSTR_W-1:0] target_aligned;

    assign pc_plus4       = pc_q + 32'd4;
    assign target_aligned = BranchTarget & ~32'h3;
    // req_en_q keeps the request low for the first cycle out of reset.
    assign IMemReq        = (state_q == FETCH) && req_en_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pcp4_d     = pcp4_q;
        valid_d    = valid_q;
        req_en_d   = 1'b1;
        pend_d     = pend_q;
        tgt_d      = tgt_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;

        if (PCSrc) begin
            instr_d    = NOP_INSTR;
            valid_d    = 1'b0;
            skid_clear = 1'b1;
            if (IMemReq && !IMemReady) begin
                // Address must stay stable until memory accepts.
                pend_d = 1'b1;
                tgt_d  = target_aligned;
            end else begin
                pc_d    = target_aligned;
                state_d = FETCH;
                pend_d  = 1'b0;
            end
        end else if (pend_q) begin
            // Stale request still in flight; its response is dropped.
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            if (IMemReady) begin
                pc_d   = tgt_q;
                pend_d = 1'b0;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (IMemReq) begin
                        if (IMemReady && !Stall) begin
                            instr_d = IMemRdata;
                            pcp4_d  = pc_plus4;
                            valid_d = 1'b1;
                            pc_d    = pc_plus4;
                        end else if (IMemReady) begin
                            skid_load = 1'b1;
                            state_d   = HOLD;
                        end else if (!Stall) begin
                            instr_d = NOP_INSTR;
                            valid_d = 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (!Stall) begin
                        state_d = FETCH;
                        if (skid_full) begin
                            skid_drain = 1'b1;
                            instr_d    = skid_data;
                            pcp4_d     = skid_pcp4;
                            valid_d    = 1'b1;
                            pc_d       = skid_pcp4;
                        end
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            pcp4_q   <= '0;
            valid_q  <= 1'b0;
            req_en_q <= 1'b0;
            pend_q   <= 1'b0;
            tgt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pcp4_q   <= pcp4_d;
            valid_q  <= valid_d;
            req_en_q <= req_en_d;
            pend_q   <= pend_d;
            tgt_q    <= tgt_d;
        end
    end

    fetch_skid_buffer u_skid (
        .Clk     (Clk),
        .Rst     (Rst),
        .load    (skid_load),
        .drain   (skid_drain),
        .clear   (skid_clear),
        .data_in (IMemRdata),
        .pcp4_in (pc_plus4),
        .full    (skid_full),
        .data    (skid_data),
        .pcp4    (skid_pcp4)
    );

    assign IMemAddr    = pc_q;
    assign Instruction = instr_q;
    assign PCPlus4     = pcp4_q;
    assign Valid       = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!valid_q && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign BubbleCount = bubble_cnt_q;
`endif

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
PC-sequencing fetch stage with an IF/ID output register. Drives the 32-bit Instruction consumed by the Controller. Consumes the Controller's PCSrc together with a branch target. Talks to instruction memory over a req/ready handshake of variable latency, honours a hazard Stall, and buffers one response so no fetched word is lost while stalled.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, bubble word driven on Instruction when invalid or flushed.

Ports:
Clk  input  1  system clock; all state changes on rising edge.
Rst  input  1  asynchronous, active-low reset (0 = reset).
Stall  input  1  hazard hold; IF/ID register and PC must not advance.
PCSrc  input  1  branch taken (from Controller); redirect fetch to BranchTarget.
BranchTarget  input  32  redirect address; sampled only when PCSrc=1.
IMemReq  output  1  fetch request to instruction memory.
IMemAddr  output  32  word-aligned fetch address; stable while IMemReq=1 and IMemReady=0.
IMemReady  input  1  memory accepts the request; IMemRdata valid in the same cycle.
IMemRdata  input  32  fetched instruction word.
Instruction  output  32  IF/ID instruction register, feeds Controller.
PCPlus4  output  32  IF/ID register holding fetched-PC+4.
Valid  output  1  Instruction holds a real instruction (0 = bubble).

Behaviour:
- Reset (Rst=0, async): PC=RESET_PC, state=FETCH, Instruction=NOP_INSTR, PCPlus4=0, Valid=0, IMemReq=0, redirect-pending=0, skid empty.
- First edge after release: IMemReq=1, IMemAddr=RESET_PC.
- FSM states:
  - FETCH: IMemReq=1, IMemAddr=PC.
    - IMemReady=1 and Stall=0: load Instruction/PCPlus4, Valid=1, PC+=4, stay FETCH. Throughput is 1 instruction/cycle with zero-wait memory.
    - IMemReady=1 and Stall=1: capture word + PC+4 into skid, go HOLD.
    - IMemReady=0: remain FETCH with address held (wait state). Valid is unchanged if Stall=1, else 0 (bubble).
  - HOLD: IMemReq=0; IF/ID frozen.
    - Stall drops: skid moves to IF/ID, Valid=1, PC+=4, go FETCH.
- PCSrc=1, any state: highest priority, overrides Stall.
  - Instruction=NOP_INSTR, Valid=0, skid discarded.
  - If no request is outstanding, or IMemReady=1 that cycle: PC=BranchTarget, state=FETCH; any response arriving that cycle is dropped.
  - If in FETCH with IMemReady=0: address must stay stable, so latch BranchTarget, set redirect-pending, keep IMemReq/IMemAddr. On the later IMemReady=1, drop the response, set PC=latched target, clear pending.
- A second PCSrc while pending overwrites the latched target (last wins).
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- BranchTarget[1:0] is ignored; treated as 00.
- Stall with Valid=1 holds Instruction/PCPlus4 bit-exact for all stall cycles.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
  - Defined: adds output BubbleCount[31:0] (reset 0). Increments each cycle Valid=0 after reset release; saturates at 32'hFFFF_FFFF. Ports and logic exist only when defined.
  - Undefined: no port, no counter; all other behaviour identical.

Decomposition:
- Shared package mips_pkg: NOP_INSTR, RESET_PC defaults, fetch state enum (FETCH, HOLD), INSTR_W=32.
- One natural sub-module: fetch_skid_buffer. One-entry data+PC+4 holder with load/drain/clear, async active-low reset.

Test Plan:
- Reset: Rst=0 mid-WAIT with IMemReq=1 -> same cycle IMemReq=0, Valid=0, Instruction=0. After release, IMemAddr=0x0.
- Zero-wait stream: IMemReady=1 always, words 0x8C01_0000, 0xAC01_0000, 0x1001_0000 -> Instruction follows 1 cycle after each accept. PCPlus4=4, 8, 12; Valid=1 continuously.
- Wait states: IMemReady low 3 cycles at addr 0x10 -> IMemAddr held at 0x10, Valid=0 for those cycles, then word loads with PCPlus4=0x14.
- Stall with response: Stall=1 as 0x0000_0020 arrives -> HOLD, IMemReq=0, IF/ID frozen. Stall=0 -> Instruction=0x0000_0020 and Valid=1 next edge; no word lost or duplicated.
- Redirect during wait: PCSrc=1, BranchTarget=0x40 while IMemReady=0 at 0x18 -> IMemAddr stays 0x18, Valid=0. After ready, response dropped and next IMemAddr=0x40.
- PCSrc with Stall=1 simultaneously -> flush wins: Valid=0, Instruction=0, PC=BranchTarget. Wrap check: PC 0xFFFF_FFFC accepted -> next IMemAddr=0x0.
